// File: rtl/spi_ram_bridge_if.sv
// Pin bundle between an SPI master and the spi_ram_bridge serial memory.
// SS_n low frames a transfer; MOSI is sampled and MISO driven on each rising clk; wr_done/rd_done are single-cycle strobes.
interface spi_ram_bridge_if;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic       busy;
    logic       wr_done;
    logic       rd_done;
    logic [2:0] fsm_state;

    modport master (
        output SS_n, MOSI,
        input  MISO, busy, wr_done, rd_done, fsm_state
    );

    modport slave (
        input  SS_n, MOSI,
        output MISO, busy, wr_done, rd_done, fsm_state
    );
endinterface

// File: rtl/spi_ram_bridge.sv
// SPI slave front end merged with a single-port RAM, with independent auto-incrementing read/write pointers.
// Opcodes (2 bits, MSB first): 00 set wr_ptr, 10 set rd_ptr, 01 write burst, 11 read burst. Needs DATA_W >= 2, ADDR_W >= 2.
module spi_ram_bridge #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    spi_ram_bridge_if.slave bus
);
    localparam int MAXW  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CNT_W = $clog2(MAXW + 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  ADDR_FULL = CNT_W'(ADDR_W);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        WDATA = 3'd3,
        TURN  = 3'd4,
        RDATA = 3'd5
    } state_t;

    state_t state, state_next;

    logic              op_hi;
    logic              tgt_rd;
    logic [CNT_W-1:0]  cnt;
    logic [MAXW-2:0]   rx;
    logic [DATA_W-2:0] tx;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              miso_q, wr_done_q, rd_done_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [MAXW-1:0]   rx_shift;
    logic [DATA_W-1:0] wr_word;
    logic [ADDR_W-1:0] addr_word;

    assign rx_shift  = {rx, bus.MOSI};
    assign wr_word   = rx_shift[DATA_W-1:0];
    // Out-of-range addresses fold back into the array rather than aliasing past it.
    assign addr_word = ADDR_W'(32'(rx_shift[ADDR_W-1:0]) % DEPTH);

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        if (!AUTO_INC) return p;
        return (p == PTR_LAST) ? '0 : p + ADDR_W'(1);
    endfunction

    logic              addr_last, wr_last, rd_wrap, rd_last;
    logic [CNT_W-1:0]  rd_idx;
    logic [ADDR_W-1:0] rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        addr_last  = 1'b0;
        wr_last    = 1'b0;
        rd_wrap    = 1'b0;
        rd_last    = 1'b0;
        rd_idx     = '0;
        rd_addr    = rd_ptr;
        case (state)
            IDLE: if (!bus.SS_n) state_next = CMD;
            CMD: begin
                if (bus.SS_n)      state_next = IDLE;
                else if (bus.MOSI) state_next = op_hi ? TURN : WDATA;
                else               state_next = ADDR;
            end
            ADDR: begin
                if (bus.SS_n) state_next = IDLE;
                else          addr_last  = (cnt == ADDR_LAST);
            end
            WDATA: begin
                if (bus.SS_n) state_next = IDLE;
                else          wr_last    = (cnt == DATA_LAST);
            end
            TURN: begin
                if (bus.SS_n) state_next = IDLE;
                else          state_next = RDATA;
            end
            RDATA: begin
                if (bus.SS_n) state_next = IDLE;
                else begin
                    // cnt is the bit index currently on MISO; rd_idx is the one the next edge places.
                    rd_wrap = (cnt == DATA_LAST);
                    rd_idx  = rd_wrap ? '0 : cnt + CNT_W'(1);
                    rd_last = (rd_idx == DATA_LAST);
                    if (rd_wrap) rd_addr = ptr_next(rd_ptr);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_hi     <= 1'b0;
            tgt_rd    <= 1'b0;
            cnt       <= '0;
            rx        <= '0;
            tx        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            miso_q    <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            miso_q    <= 1'b0;
            wr_done_q <= wr_last;
            rd_done_q <= rd_last;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!bus.SS_n) op_hi <= bus.MOSI;
                end
                CMD: begin
                    cnt    <= '0;
                    tgt_rd <= op_hi;
                end
                ADDR: begin
                    // Bits after the address are ignored until the frame closes.
                    if (!bus.SS_n && cnt != ADDR_FULL) begin
                        rx  <= rx_shift[MAXW-2:0];
                        cnt <= cnt + CNT_W'(1);
                        if (addr_last) begin
                            if (tgt_rd) rd_ptr <= addr_word;
                            else        wr_ptr <= addr_word;
                        end
                    end
                end
                WDATA: begin
                    if (!bus.SS_n) begin
                        rx <= rx_shift[MAXW-2:0];
                        if (wr_last) begin
                            cnt    <= '0;
                            wr_ptr <= ptr_next(wr_ptr);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                TURN: begin
                    if (!bus.SS_n) begin
                        tx     <= mem[rd_ptr][DATA_W-2:0];
                        miso_q <= mem[rd_ptr][DATA_W-1];
                        cnt    <= '0;
                    end
                end
                RDATA: begin
                    if (!bus.SS_n) begin
                        cnt <= rd_idx;
                        if (rd_wrap) begin
                            rd_ptr <= rd_addr;
                            tx     <= mem[rd_addr][DATA_W-2:0];
                            miso_q <= mem[rd_addr][DATA_W-1];
                        end else begin
                            tx     <= tx << 1;
                            miso_q <= tx[DATA_W-2];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_last) mem[wr_ptr] <= wr_word;
    end

    assign bus.MISO      = miso_q;
    assign bus.busy      = (state != IDLE);
    assign bus.wr_done   = wr_done_q;
    assign bus.rd_done   = rd_done_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_spi_ram_bridge.sv
// Bench for spi_ram_bridge: directed SPI frames, expected words queued at issue time, monitors compare on wr_done/rd_done.
module tb_spi_ram_bridge;
    localparam logic [2:0] RDATA_ST = 3'd5;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic ss_n;
    logic mosi;

    int tests;
    int errors;
    int wr2_cnt;

    logic [7:0]  model_mem [256];
    logic [7:0]  model_wr_ptr, model_rd_ptr, model2_wr_ptr;
    logic [15:0] exp_wr_q[$];
    logic [15:0] exp_wr2_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  rd_col;
    logic [15:0] wr_e, wr2_e;

    always #5 clk = ~clk;

    spi_ram_bridge_if bus1();
    spi_ram_bridge_if bus2();

    assign bus1.SS_n = sel ? 1'b1 : ss_n;
    assign bus1.MOSI = mosi;
    assign bus2.SS_n = sel ? ss_n : 1'b1;
    assign bus2.MOSI = mosi;

    spi_ram_bridge #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .AUTO_INC(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    spi_ram_bridge #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .AUTO_INC(1'b0)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        ss_n = 1'b0;
        mosi = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic end_frame();
        ss_n = 1'b1;
        mosi = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic rd, input logic [7:0] a);
        send_bit(rd);
        send_bit(1'b0);
        send_bits(a, 8);
        end_frame();
        if (sel)     model2_wr_ptr = a;
        else if (rd) model_rd_ptr  = a;
        else         model_wr_ptr  = a;
    endtask

    task automatic write_open();
        send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic write_word(input logic [7:0] d);
        if (sel) begin
            exp_wr2_q.push_back({model2_wr_ptr, d});
        end else begin
            exp_wr_q.push_back({model_wr_ptr, d});
            model_mem[model_wr_ptr] = d;
            model_wr_ptr = model_wr_ptr + 8'd1;
        end
        send_bits(d, 8);
    endtask

    // Holds SS_n low for 1 + 8*n edges after the opcode, as a master would.
    task automatic read_burst(input int n);
        logic [7:0] first;
        send_bit(1'b1);
        send_bit(1'b1);
        check("turn_miso_low", {31'd0, bus1.MISO}, 32'd0);
        for (int w = 0; w < n; w++) exp_rd_q.push_back(model_mem[8'(model_rd_ptr + 8'(w))]);
        first = model_mem[model_rd_ptr];
        send_bit(1'b0);
        check("rd_latency_msb", {31'd0, bus1.MISO}, {31'd0, first[7]});
        repeat (8 * n) send_bit(1'b0);
        model_rd_ptr = model_rd_ptr + 8'(n);
        end_frame();
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (bus1.fsm_state == RDATA_ST) rd_col = {rd_col[6:0], bus1.MISO};
        else                            rd_col = 8'h00;
        if (bus1.rd_done) begin
            if (exp_rd_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL rd_done_unexpected: got word %0h expected no pulse", rd_col);
            end else begin
                check("rd_word", {24'd0, rd_col}, {24'd0, exp_rd_q.pop_front()});
            end
        end
        if (bus1.wr_done) begin
            if (exp_wr_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL wr_done_unexpected: got pulse expected none");
            end else begin
                wr_e = exp_wr_q.pop_front();
                check("mem_after_write", {24'd0, dut.mem[wr_e[15:8]]}, {24'd0, wr_e[7:0]});
            end
        end
    end

    always @(negedge clk) begin
        if (bus2.wr_done) begin
            wr2_cnt++;
            if (exp_wr2_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL wr2_done_unexpected: got pulse expected none");
            end else begin
                wr2_e = exp_wr2_q.pop_front();
                check("mem2_after_write", {24'd0, dut2.mem[wr2_e[15:8]]}, {24'd0, wr2_e[7:0]});
            end
        end
        if (bus2.rd_done) begin
            tests++;
            errors++;
            $display("FAIL rd2_done_unexpected: got pulse expected none");
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        tests = 0; errors = 0; wr2_cnt = 0;
        sel = 1'b0; ss_n = 1'b1; mosi = 1'b0; rst = 1'b1;
        rd_col = 8'h00;
        model_wr_ptr = 8'h00; model_rd_ptr = 8'h00; model2_wr_ptr = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",    {31'd0, bus1.busy},    32'd0);
        check("rst_miso",    {31'd0, bus1.MISO},    32'd0);
        check("rst_wr_done", {31'd0, bus1.wr_done}, 32'd0);
        check("rst_rd_done", {31'd0, bus1.rd_done}, 32'd0);
        check("rst_wr_ptr",  {24'd0, dut.wr_ptr},   32'h00);
        check("rst_rd_ptr",  {24'd0, dut.rd_ptr},   32'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Burst write at 0x10
        set_addr(1'b0, 8'h10);
        write_open();
        check("busy_in_frame", {31'd0, bus1.busy}, 32'd1);
        write_word(8'hA5);
        write_word(8'h3C);
        end_frame();
        check("t1_wr_ptr", {24'd0, dut.wr_ptr}, 32'h12);

        // Burst read back from 0x10
        set_addr(1'b1, 8'h10);
        read_burst(2);
        check("t2_rd_ptr", {24'd0, dut.rd_ptr}, 32'h12);

        // Pointer wrap at DEPTH-1
        set_addr(1'b0, 8'hFF);
        write_open();
        write_word(8'h11);
        write_word(8'h22);
        end_frame();
        check("t3_wr_ptr", {24'd0, dut.wr_ptr}, 32'h01);
        set_addr(1'b1, 8'hFF);
        read_burst(2);
        check("t3_rd_ptr", {24'd0, dut.rd_ptr}, 32'h01);

        // Aborted write: 5 of 8 data bits, then SS_n high
        write_open();
        send_bits(8'h16, 5);
        ss_n = 1'b1;
        @(posedge clk);
        #1;
        check("t4_busy_after_abort", {31'd0, bus1.busy}, 32'd0);
        check("t4_wr_ptr_held", {24'd0, dut.wr_ptr}, 32'h01);
        @(posedge clk);
        #1;
        write_open();
        write_word(8'h5A);
        end_frame();
        check("t4_wr_ptr_after", {24'd0, dut.wr_ptr}, 32'h02);
        set_addr(1'b1, 8'h01);
        read_burst(1);

        // Async reset in the middle of a read word
        set_addr(1'b1, 8'h10);
        send_bit(1'b1);
        send_bit(1'b1);
        repeat (3) send_bit(1'b0);
        check("t5_miso_pre", {31'd0, bus1.MISO}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_miso",    {31'd0, bus1.MISO},    32'd0);
        check("t5_busy",    {31'd0, bus1.busy},    32'd0);
        check("t5_rd_done", {31'd0, bus1.rd_done}, 32'd0);
        check("t5_wr_ptr",  {24'd0, dut.wr_ptr},   32'h00);
        check("t5_rd_ptr",  {24'd0, dut.rd_ptr},   32'h00);
        ss_n = 1'b1;
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        model_wr_ptr = 8'h00;
        model_rd_ptr = 8'h00;
        model2_wr_ptr = 8'h00;
        write_open();
        write_word(8'h77);
        end_frame();
        read_burst(1);

        // Fixed-pointer build: three words land on the same address
        sel = 1'b1;
        set_addr(1'b0, 8'h20);
        write_open();
        write_word(8'h01);
        write_word(8'h02);
        write_word(8'h03);
        end_frame();
        check("t6_mem",     {24'd0, dut2.mem[8'h20]}, 32'h03);
        check("t6_wr_ptr",  {24'd0, dut2.wr_ptr},     32'h20);
        check("t6_wr_done", wr2_cnt,                  32'd3);
        sel = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("wr_q_drained",  exp_wr_q.size(),  32'd0);
        check("wr2_q_drained", exp_wr2_q.size(), 32'd0);
        check("rd_q_drained",  exp_rd_q.size(),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
